load_align_queue: RTL

//  Parametrised load-return unit for the memory/writeback boundary. Queues metadata for
//  up to DEPTH outstanding loads (funct3, address low bits, rd tag), pairs each in-order

---
 rtl/load_align_queue_if.sv | 30 +++
 rtl/load_align_queue.sv | 93 +++++++++
 2 files changed

// File: rtl/load_align_queue_if.sv
// load_align_queue_if: request, response and result signals of the load-return unit
interface load_align_queue_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [2:0]       req_addr_lo;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_data;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic             out_misalign;
  logic             busy;
  modport master (
    output flush, req_valid, req_funct3, req_addr_lo, req_tag, rsp_valid, rsp_data, out_ready,
    input  req_ready, rsp_ready, out_valid, out_data, out_tag, out_illegal, out_misalign, busy
  );
  modport slave (
    input  flush, req_valid, req_funct3, req_addr_lo, req_tag, rsp_valid, rsp_data, out_ready,
    output req_ready, rsp_ready, out_valid, out_data, out_tag, out_illegal, out_misalign, busy
  );
endinterface

// File: rtl/load_align_queue.sv
// load_align_queue: in-order load metadata queue pairing DMEM responses, with byte alignment and sign/zero extension; MISALIGN_CHECK_EN flags and zeroes misaligned results
module load_align_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input logic clk,
  input logic rst,
  load_align_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [2:0]       q_f3  [DEPTH];
  logic [2:0]       q_off [DEPTH];
  logic [TAG_W-1:0] q_tag [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop;
  logic [2:0]       f3, off;
  logic [XLEN-1:0]  shifted, ext, data_n;
  logic             legal, mis_n;
  logic             out_valid, out_illegal, out_misalign;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;
  assign bus.req_ready = count != CW'(DEPTH);
  assign bus.rsp_ready = (count != '0) & (!out_valid | bus.out_ready);
  assign push = bus.req_valid & bus.req_ready;
  assign pop  = bus.rsp_valid & bus.rsp_ready;
  // occupancy and wrap-around pointers; flush drops everything queued
  always_ff @(posedge clk)
    if (rst || bus.flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  // metadata storage, written at the tail on every accepted request
  always_ff @(posedge clk)
    if (push) begin
      q_f3[wr_ptr]  <= bus.req_funct3;
      q_off[wr_ptr] <= bus.req_addr_lo;
      q_tag[wr_ptr] <= bus.req_tag;
    end
  assign f3      = q_f3[rd_ptr];
  assign off     = XLEN == 64 ? q_off[rd_ptr] : {1'b0, q_off[rd_ptr][1:0]};
  assign shifted = bus.rsp_data >> {off, 3'b000};
  // funct3 decode: width, signedness and legality for this XLEN
  always_comb begin
    ext   = '0;
    legal = 1'b1;
    case (f3)
      3'b000: ext = XLEN'($signed(shifted[7:0]));
      3'b001: ext = XLEN'($signed(shifted[15:0]));
      3'b010: ext = XLEN'($signed(shifted[31:0]));
      3'b011: begin ext = shifted; legal = XLEN == 64; end
      3'b100: ext = XLEN'(shifted[7:0]);
      3'b101: ext = XLEN'(shifted[15:0]);
      3'b110: begin ext = XLEN'(shifted[31:0]); legal = XLEN == 64; end
      default: legal = 1'b0;
    endcase
  end
`ifdef MISALIGN_CHECK_EN
  assign mis_n  = legal & (f3[1:0] == 2'b01 ? off[0] : f3[1:0] == 2'b10 ? |off[1:0] : f3[1:0] == 2'b11 ? |off : 1'b0);
  assign data_n = (!legal || mis_n) ? '0 : ext;
`else
  assign mis_n  = 1'b0;
  assign data_n = legal ? ext : '0;
`endif
  // result register: loads on pop, holds under backpressure, drops valid after handshake
  always_ff @(posedge clk)
    if (rst || bus.flush) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_tag      <= '0;
      out_illegal  <= 1'b0;
      out_misalign <= 1'b0;
    end else if (pop) begin
      out_valid    <= 1'b1;
      out_data     <= data_n;
      out_tag      <= q_tag[rd_ptr];
      out_illegal  <= !legal;
      out_misalign <= mis_n;
    end else if (bus.out_ready) out_valid <= 1'b0;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_data;
  assign bus.out_tag      = out_tag;
  assign bus.out_illegal  = out_illegal;
  assign bus.out_misalign = out_misalign;
  assign bus.busy         = (count != '0) | out_valid;
endmodule
